// File: rtl/regfile_16.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_16
//  Purpose  : Sixteen-entry, 32-bit register file with one synchronous write
//             port, two combinational read ports and a per-register busy
//             scoreboard for multi-cycle writers (mult/div). r0 reads as zero
//             and can never be marked busy.
//  Ports    : clock, reset          - rising-edge clock, sync active-high reset
//             we, waddr, wdata      - write port (also clears busy[waddr])
//             raddr_a/b, rdata_a/b  - combinational read ports
//             set_busy, busy_addr   - mark a register as having a pending write
//             busy_a/b              - scoreboard bit of raddr_a / raddr_b
//             busy_any              - OR of all busy bits
//  Config   : REGFILE_BYPASS_EN     - when defined, a read of the register
//             being written this cycle returns wdata (write-to-read forwarding)
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_16 (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        set_busy,
  input  logic [3:0]  busy_addr,
  output logic        busy_a,
  output logic        busy_b,
  output logic        busy_any
);

  logic [31:0] regs [16];
  logic [15:0] busy;

  logic        wr_ok;
  logic        set_ok;
  logic [31:0] stored_a;
  logic [31:0] stored_b;

  // Index 0 is excluded from both writes and busy marking.
  assign wr_ok  = we && (waddr != 4'd0);
  assign set_ok = set_busy && (busy_addr != 4'd0);

  // The set is applied after the write-clear so that a set and a write to the
  // same index leave the busy bit at 1 (a new op may issue on the retire cycle).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (set_ok) begin
        busy[busy_addr] <= 1'b1;
      end
    end
  end

  // r0 is forced to zero on the read side as well, so it reads 0 even before
  // the first reset.
  assign stored_a = (raddr_a == 4'd0) ? 32'd0 : regs[raddr_a];
  assign stored_b = (raddr_b == 4'd0) ? 32'd0 : regs[raddr_b];

  assign busy_any = |busy[15:1];

`ifdef REGFILE_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  // wr_ok already excludes index 0, so r0 never forwards.
  assign fwd_a = wr_ok && (waddr == raddr_a);
  assign fwd_b = wr_ok && (waddr == raddr_b);

  // A forwarded read sees the write's clearing of busy, unless a set to the
  // same index lands in the same cycle (set wins).
  always_comb begin
    rdata_a = stored_a;
    rdata_b = stored_b;
    busy_a  = busy[raddr_a];
    busy_b  = busy[raddr_b];
    if (fwd_a) begin
      rdata_a = wdata;
      busy_a  = set_ok && (busy_addr == raddr_a);
    end
    if (fwd_b) begin
      rdata_b = wdata;
      busy_b  = set_ok && (busy_addr == raddr_b);
    end
  end
`else
  always_comb begin
    rdata_a = stored_a;
    rdata_b = stored_b;
    busy_a  = (raddr_a != 4'd0) && busy[raddr_a];
    busy_b  = (raddr_b != 4'd0) && busy[raddr_b];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_16
//  Purpose  : Self-checking bench for regfile_16. Expected output values are
//             queued when stimulus is applied and popped/compared at the
//             following falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_16;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int SEL_RA   = 0;
  localparam int SEL_RB   = 1;
  localparam int SEL_BA   = 2;
  localparam int SEL_BB   = 3;
  localparam int SEL_BANY = 4;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        set_busy;
  logic [3:0]  busy_addr;
  logic        busy_a;
  logic        busy_b;
  logic        busy_any;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  regfile_16 dut (
    .clock     (clock),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .set_busy  (set_busy),
    .busy_addr (busy_addr),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .busy_any  (busy_any)
  );

  always #5 clock = ~clock;

  task automatic push(input int sel, input logic [31:0] val, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Wait for the falling edge, then drain the scoreboard against the outputs.
  task automatic check_now();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clock);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_RA:   obs = rdata_a;
        SEL_RB:   obs = rdata_b;
        SEL_BA:   obs = {31'd0, busy_a};
        SEL_BB:   obs = {31'd0, busy_b};
        default:  obs = {31'd0, busy_any};
      endcase
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset, with a write and a set attempted in the same cycle (reset wins).
    reset = 1'b1; we = 1'b1; waddr = 4'd5; wdata = 32'hDEAD_BEEF;
    set_busy = 1'b1; busy_addr = 4'd5; raddr_a = 4'd0; raddr_b = 4'd0;
    tick();
    reset = 1'b0; we = 1'b0; set_busy = 1'b0;
    raddr_a = 4'd5; raddr_b = 4'd15;
    push(SEL_RA,   32'd0, "reset_rdata_a");
    push(SEL_RB,   32'd0, "reset_rdata_b");
    push(SEL_BA,   32'd0, "reset_busy_a");
    push(SEL_BB,   32'd0, "reset_busy_b");
    push(SEL_BANY, 32'd0, "reset_busy_any");
    check_now();

    // Write every register 1..15, then read pairs (i, 16-i).
    for (int i = 1; i < 16; i++) begin
      tick();
      we = 1'b1; waddr = 4'(i); wdata = 32'hA5A5_0000 + 32'(i);
    end
    tick();
    we = 1'b0;
    for (int i = 1; i < 16; i++) begin
      raddr_a = 4'(i); raddr_b = 4'(16 - i);
      push(SEL_RA, 32'hA5A5_0000 + 32'(i),      "pair_rdata_a");
      push(SEL_RB, 32'hA5A5_0000 + 32'(16 - i), "pair_rdata_b");
      check_now();
    end

    // r0 ignores writes.
    tick();
    we = 1'b1; waddr = 4'd0; wdata = 32'hFFFF_FFFF; raddr_a = 4'd0; raddr_b = 4'd0;
    push(SEL_RA, 32'd0, "r0_write_same_cycle");
    check_now();
    tick();
    we = 1'b0;
    push(SEL_RA, 32'd0, "r0_after_write_a");
    push(SEL_RB, 32'd0, "r0_after_write_b");
    check_now();

    // Same-cycle read of the register being written.
    tick();
    we = 1'b1; waddr = 4'd7; wdata = 32'h1234_5678; raddr_a = 4'd7; raddr_b = 4'd6;
    push(SEL_RA, BYP ? 32'h1234_5678 : 32'hA5A5_0007, "bypass_same_cycle");
    push(SEL_RB, 32'hA5A5_0006, "bypass_other_port");
    check_now();
    tick();
    we = 1'b0;
    push(SEL_RA, 32'h1234_5678, "write_next_cycle");
    check_now();

    // Scoreboard lifecycle on r9; set on r0 is ignored.
    tick();
    set_busy = 1'b1; busy_addr = 4'd9; raddr_a = 4'd9;
    push(SEL_BA, 32'd0, "busy_not_yet");
    check_now();
    tick();
    set_busy = 1'b0;
    push(SEL_BA,   32'd1, "busy_set_a");
    push(SEL_BANY, 32'd1, "busy_set_any");
    check_now();
    tick();
    we = 1'b1; waddr = 4'd9; wdata = 32'h42;
    push(SEL_BA, BYP ? 32'd0 : 32'd1,             "busy_clear_same_cycle");
    push(SEL_RA, BYP ? 32'h42 : 32'hA5A5_0009,    "retire_data_same_cycle");
    check_now();
    tick();
    we = 1'b0;
    push(SEL_BA,   32'd0,  "busy_cleared_a");
    push(SEL_BANY, 32'd0,  "busy_cleared_any");
    push(SEL_RA,   32'h42, "retire_data");
    check_now();
    tick();
    set_busy = 1'b1; busy_addr = 4'd0; raddr_a = 4'd0;
    tick();
    set_busy = 1'b0;
    push(SEL_BA,   32'd0, "r0_busy_ignored");
    push(SEL_BANY, 32'd0, "r0_busy_any");
    check_now();

    // Simultaneous set and write on r3: set wins, data is written.
    tick();
    we = 1'b1; waddr = 4'd3; wdata = 32'h0BAD;
    set_busy = 1'b1; busy_addr = 4'd3; raddr_b = 4'd3;
    push(SEL_RB, BYP ? 32'h0BAD : 32'hA5A5_0003, "setwr_data_same_cycle");
    push(SEL_BB, BYP ? 32'd1 : 32'd0,            "setwr_busy_same_cycle");
    check_now();
    tick();
    we = 1'b0; set_busy = 1'b0;
    push(SEL_RB,   32'h0BAD, "setwr_data");
    push(SEL_BB,   32'd1,    "setwr_busy");
    push(SEL_BANY, 32'd1,    "setwr_busy_any");
    check_now();

    // Different indices in the same cycle: clear r3, set r11.
    tick();
    we = 1'b1; waddr = 4'd3; wdata = 32'h1;
    set_busy = 1'b1; busy_addr = 4'd11; raddr_a = 4'd11;
    tick();
    we = 1'b0; set_busy = 1'b0;
    push(SEL_RB,   32'h1, "split_data_r3");
    push(SEL_BB,   32'd0, "split_busy_r3");
    push(SEL_BA,   32'd1, "split_busy_r11");
    push(SEL_BANY, 32'd1, "split_busy_any");
    check_now();
    tick();
    we = 1'b1; waddr = 4'd11; wdata = 32'h5;
    tick();
    we = 1'b0;
    push(SEL_BANY, 32'd0, "split_all_clear");
    push(SEL_RA,   32'h5, "split_data_r11");
    check_now();

    // Reset in the middle of an outstanding op on r4.
    tick();
    we = 1'b1; waddr = 4'd4; wdata = 32'h77;
    tick();
    we = 1'b0; set_busy = 1'b1; busy_addr = 4'd4;
    tick();
    // Setting an already-busy bit keeps it at 1.
    tick();
    set_busy = 1'b0; raddr_a = 4'd4; raddr_b = 4'd15;
    push(SEL_BA, 32'd1,  "midop_busy");
    push(SEL_RA, 32'h77, "midop_data");
    check_now();
    tick();
    reset = 1'b1; we = 1'b1; waddr = 4'd4; wdata = 32'h99;
    tick();
    reset = 1'b0; we = 1'b0;
    push(SEL_RA,   32'd0, "midop_reset_r4");
    push(SEL_RB,   32'd0, "midop_reset_r15");
    push(SEL_BA,   32'd0, "midop_reset_busy");
    push(SEL_BANY, 32'd0, "midop_reset_busy_any");
    check_now();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
